flash_addr_sequencer: RTL and testbench

FLASH_ADDR_SEQUENCER -- requirements
Module: flash_addr_sequencer

---
 rtl/flash_addr_pkg.sv | 17 +
 rtl/flash_addr_step_calc.sv | 66 ++++++
 rtl/flash_addr_sequencer.sv | 146 ++++++++++++++
 tb/tb_flash_addr_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_addr_pkg.sv
// Shared types and default geometry for the flash address sequencer.
// Used by flash_addr_sequencer and flash_addr_step_calc.
package flash_addr_pkg;

  localparam int unsigned DEF_WIDTH      = 32'd23;
  localparam int unsigned DEF_START_ADDR = 32'h0000_0000;
  localparam int unsigned DEF_END_ADDR   = 32'h0007_FFFF;
  localparam int unsigned DEF_STEP_W     = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/flash_addr_step_calc.sv
// Combinational next-address calculator for one stride step.
// Detects overshoot/undershoot in WIDTH+1 bits and chooses between wrap and clamp.
module flash_addr_step_calc
  import flash_addr_pkg::*;
#(
  parameter int unsigned          WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0]     START_ADDR = WIDTH'(DEF_START_ADDR),
  parameter logic [WIDTH-1:0]     END_ADDR   = WIDTH'(DEF_END_ADDR),
  parameter int unsigned          STEP_W     = DEF_STEP_W
) (
  input  logic [WIDTH-1:0]  addr,
  input  logic              forward,
  input  logic [STEP_W-1:0] stride,
  input  logic              loop_en,
  output logic [WIDTH-1:0]  next_addr,
  output logic              wrap,
  output logic              stop
);

  localparam int unsigned      EW        = WIDTH + 32'd1;
  localparam logic [EW-1:0]    START_EXT = {1'b0, START_ADDR};
  localparam logic [EW-1:0]    END_EXT   = {1'b0, END_ADDR};
  localparam logic [EW-1:0]    SPAN      = END_EXT - START_EXT;

  logic [STEP_W-1:0] stride_eff_s;
  logic [EW-1:0]     addr_ext_s;
  logic [EW-1:0]     step_ext_s;
  logic [EW-1:0]     sum_s;
  logic [EW-1:0]     cur_off_s;
  logic [EW-1:0]     sum_off_s;
  logic              cur_out_s;
  logic              crossed_s;

  assign stride_eff_s = (stride == {STEP_W{1'b0}}) ? STEP_W'(1'b1) : stride;
  assign addr_ext_s   = {1'b0, addr};
  assign step_ext_s   = EW'(stride_eff_s);
  assign sum_s        = forward ? (addr_ext_s + step_ext_s) : (addr_ext_s - step_ext_s);

  // Offsets from START: anything below START borrows into a huge value, so a
  // single unsigned compare against the span covers both ends of the range.
  assign cur_off_s = addr_ext_s - START_EXT;
  assign sum_off_s = sum_s - START_EXT;
  assign cur_out_s = (cur_off_s > SPAN);
  assign crossed_s = (sum_off_s > SPAN);

  // Select the stepped, wrapped or clamped address.
  always_comb begin
    next_addr = addr;
    wrap      = 1'b0;
    stop      = 1'b0;
    if (cur_out_s) begin
      next_addr = START_ADDR;
    end else if (crossed_s) begin
      if (loop_en) begin
        next_addr = forward ? START_ADDR : END_ADDR;
        wrap      = 1'b1;
      end else begin
        next_addr = forward ? END_ADDR : START_ADDR;
        stop      = 1'b1;
      end
    end else begin
      next_addr = sum_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/flash_addr_sequencer.sv
// Playback address sequencer for a flash controller: start/step/pause/wrap/one-shot.
// Optional bookmark (mark/recall) support is built when FLASH_ADDR_BOOKMARK_EN is defined.
module flash_addr_sequencer
  import flash_addr_pkg::*;
#(
  parameter int unsigned          WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0]     START_ADDR = WIDTH'(DEF_START_ADDR),
  parameter logic [WIDTH-1:0]     END_ADDR   = WIDTH'(DEF_END_ADDR),
  parameter int unsigned          STEP_W     = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              change,
  input  logic              forward,
  input  logic [STEP_W-1:0] stride,
  input  logic              loop_en,
  input  logic              pause,
`ifdef FLASH_ADDR_BOOKMARK_EN
  input  logic              mark,
  input  logic              recall,
`endif
  output logic [WIDTH-1:0]  address,
  output logic              addr_valid,
  output logic              wrapped,
  output logic              done
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [WIDTH-1:0]  addr_nxt_s;
  logic              wrap_nxt_s;
  logic              valid_nxt_s;
  logic              done_nxt_s;
  logic [WIDTH-1:0]  step_addr_s;
  logic              step_wrap_s;
  logic              step_stop_s;
  logic              step_take_s;
  logic              playing_s;

  assign playing_s = (state_r == ST_RUN) || (state_r == ST_PAUSED);

`ifdef FLASH_ADDR_BOOKMARK_EN
  logic [WIDTH-1:0]  bookmark_r;
  logic              recall_take_s;

  assign recall_take_s = recall && !start && playing_s;
  assign step_take_s   = change && !start && !recall && (state_r == ST_RUN) && !pause;

  // Bookmark register: captures the address currently presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bookmark_r <= START_ADDR;
    end else if (mark) begin
      bookmark_r <= address;
    end else begin
      bookmark_r <= bookmark_r;
    end
  end
`else
  assign step_take_s = change && !start && (state_r == ST_RUN) && !pause;
`endif

  flash_addr_step_calc #(
    .WIDTH      (WIDTH),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR),
    .STEP_W     (STEP_W)
  ) u_step (
    .addr      (address),
    .forward   (forward),
    .stride    (stride),
    .loop_en   (loop_en),
    .next_addr (step_addr_s),
    .wrap      (step_wrap_s),
    .stop      (step_stop_s)
  );

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      address    <= START_ADDR;
      addr_valid <= 1'b0;
      wrapped    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      address    <= addr_nxt_s;
      addr_valid <= valid_nxt_s;
      wrapped    <= wrap_nxt_s;
      done       <= done_nxt_s;
    end
  end

  // Next-state logic; start restarts playback from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (start) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_IDLE:   state_nxt_s = ST_IDLE;
        ST_RUN: begin
          if (pause) begin
            state_nxt_s = ST_PAUSED;
          end else if (step_take_s && step_stop_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PAUSED;
          end
        end
        ST_DONE:   state_nxt_s = ST_DONE;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output logic: address/wrap update and flags for the coming state.
  always_comb begin
    addr_nxt_s  = address;
    wrap_nxt_s  = 1'b0;
    valid_nxt_s = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_PAUSED);
    done_nxt_s  = (state_nxt_s == ST_DONE);
    if (start) begin
      addr_nxt_s = forward ? START_ADDR : END_ADDR;
`ifdef FLASH_ADDR_BOOKMARK_EN
    end else if (recall_take_s) begin
      addr_nxt_s = bookmark_r;
`endif
    end else if (step_take_s) begin
      addr_nxt_s = step_addr_s;
      wrap_nxt_s = step_wrap_s;
    end else begin
      addr_nxt_s = address;
    end
  end

endmodule

// File: tb/tb_flash_addr_sequencer.sv
// Directed self-checking bench for flash_addr_sequencer (START 'h10, END 'h1F, WIDTH 8).
// Define FLASH_ADDR_BOOKMARK_EN to also exercise mark/recall.
module tb_flash_addr_sequencer;

  localparam int SA = 'h10;
  localparam int EA = 'h1F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       change = 1'b0;
  logic       forward = 1'b1;
  logic [3:0] stride = 4'd0;
  logic       loop_en = 1'b0;
  logic       pause = 1'b0;
  logic       mark = 1'b0;
  logic       recall = 1'b0;
  logic [7:0] address;
  logic       addr_valid;
  logic       wrapped;
  logic       done;

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_DONE} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_addr = SA;
  int      m_mark = SA;
  bit      m_wrap = 1'b0;

  flash_addr_sequencer #(
    .WIDTH      (8),
    .START_ADDR (8'h10),
    .END_ADDR   (8'h1F),
    .STEP_W     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .change     (change),
    .forward    (forward),
    .stride     (stride),
    .loop_en    (loop_en),
    .pause      (pause),
`ifdef FLASH_ADDR_BOOKMARK_EN
    .mark       (mark),
    .recall     (recall),
`endif
    .address    (address),
    .addr_valid (addr_valid),
    .wrapped    (wrapped),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_addr  = SA;
    m_mark  = SA;
    m_wrap  = 1'b0;
  endtask

  // Spec-level playback model, applied once per rising edge with the inputs held across it.
  task automatic model_edge();
    mstate_t ns = m_state;
    int      na = m_addr;
    bit      nw = 1'b0;
    int      s  = (stride == 4'd0) ? 1 : int'(stride);
    int      nx;
    bit      rec = recall && (m_state == M_RUN || m_state == M_PAUSED);
    if (start) begin
      na = forward ? SA : EA;
      ns = M_RUN;
    end else begin
      if (m_state == M_RUN && pause) ns = M_PAUSED;
      else if (m_state == M_PAUSED && !pause) ns = M_RUN;
      if (rec) begin
        na = m_mark;
      end else if (change && m_state == M_RUN && !pause) begin
        if (m_addr < SA || m_addr > EA) begin
          na = SA;
        end else begin
          nx = forward ? m_addr + s : m_addr - s;
          if (nx > EA || nx < SA) begin
            if (loop_en) begin
              na = forward ? SA : EA;
              nw = 1'b1;
            end else begin
              na = forward ? EA : SA;
              ns = M_DONE;
            end
          end else begin
            na = nx;
          end
        end
      end
    end
    if (mark) m_mark = m_addr;
    m_state = ns;
    m_addr  = na;
    m_wrap  = nw;
  endtask

  // One clock: drive inputs, let the model follow the edge, return at the falling edge.
  task automatic cyc(input bit st, input bit ch, input bit fw, input int sd,
                     input bit lp, input bit ps, input bit mk = 1'b0, input bit rc = 1'b0);
    start   = st;
    change  = ch;
    forward = fw;
    stride  = 4'(sd);
    loop_en = lp;
    pause   = ps;
    mark    = mk;
    recall  = rc;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    start  = 1'b0;
    change = 1'b0;
    mark   = 1'b0;
    recall = 1'b0;
  endtask

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_address", address, m_addr);
      chk("model_valid", addr_valid, (m_state == M_RUN || m_state == M_PAUSED) ? 1 : 0);
      chk("model_wrapped", wrapped, m_wrap);
      chk("model_done", done, (m_state == M_DONE) ? 1 : 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_addr", address, 'h10);
    chk("reset_valid", addr_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_wrapped", wrapped, 0);
    cmp_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(0, 1, 1, 4, 0, 0);
    chk("idle_change_ignored", address, 'h10);
    chk("idle_not_valid", addr_valid, 0);

    cyc(1, 0, 1, 4, 0, 0);
    chk("start_fwd_addr", address, 'h10);
    chk("start_valid", addr_valid, 1);
    cyc(0, 1, 1, 4, 0, 0);
    chk("step1", address, 'h14);
    cyc(0, 1, 1, 4, 0, 0);
    chk("step2", address, 'h18);
    cyc(0, 1, 1, 4, 0, 0);
    chk("step3", address, 'h1C);

    cyc(0, 1, 1, 4, 1, 0);
    chk("wrap_fwd_addr", address, 'h10);
    chk("wrap_fwd_pulse", wrapped, 1);
    cyc(0, 0, 1, 4, 1, 0);
    chk("wrap_pulse_end", wrapped, 0);
    chk("hold_no_event", address, 'h10);

    cyc(0, 1, 1, 2, 1, 0);
    chk("step_to_12", address, 'h12);
    cyc(0, 1, 0, 4, 0, 0);
    chk("clamp_low_addr", address, 'h10);
    chk("clamp_low_done", done, 1);
    chk("clamp_low_nowrap", wrapped, 0);
    cyc(0, 1, 0, 4, 0, 0);
    chk("done_hold_addr", address, 'h10);
    cyc(1, 0, 0, 4, 0, 0);
    chk("start_bwd_addr", address, 'h1F);
    chk("start_bwd_done", done, 0);
    chk("start_bwd_valid", addr_valid, 1);

    cyc(0, 1, 0, 15, 0, 0);
    chk("exact_endpoint_addr", address, 'h10);
    chk("exact_endpoint_done", done, 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("stride_zero_is_one", address, 'h11);

    cyc(0, 0, 1, 4, 0, 1);
    repeat (5) cyc(0, 1, 1, 4, 0, 1);
    chk("paused_hold", address, 'h11);
    chk("paused_valid", addr_valid, 1);
    cyc(0, 0, 1, 4, 0, 0);
    cyc(0, 1, 1, 4, 0, 0);
    chk("resume_step", address, 'h15);

    cyc(0, 1, 1, 15, 0, 0);
    chk("clamp_high_addr", address, 'h1F);
    chk("clamp_high_done", done, 1);
    cyc(1, 0, 0, 4, 1, 0);
    cyc(0, 1, 0, 15, 1, 0);
    cyc(0, 1, 0, 1, 1, 0);
    chk("wrap_bwd_addr", address, 'h1F);
    chk("wrap_bwd_pulse", wrapped, 1);

    cyc(1, 0, 1, 4, 0, 0);
    cyc(0, 1, 1, 8, 0, 0);
    chk("reach_18", address, 'h18);
    cyc(1, 1, 1, 4, 0, 0);
    chk("start_beats_change", address, 'h10);
    cyc(0, 1, 1, 4, 0, 0);
    chk("run_before_reset", address, 'h14);

    change = 1'b1;
    stride = 4'd4;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrun_reset_addr", address, 'h10);
    chk("midrun_reset_valid", addr_valid, 0);
    chk("midrun_reset_done", done, 0);
    @(negedge clk);
    change = 1'b0;
    rst_n  = 1'b1;
    cyc(0, 1, 1, 4, 0, 0);
    chk("after_reset_idle", address, 'h10);
    chk("after_reset_invalid", addr_valid, 0);

`ifdef FLASH_ADDR_BOOKMARK_EN
    cyc(1, 0, 1, 4, 0, 0);
    cyc(0, 1, 1, 4, 0, 0);
    cyc(0, 0, 1, 4, 0, 0, 1, 0);
    cyc(0, 1, 1, 4, 0, 0);
    cyc(0, 1, 1, 4, 0, 0);
    chk("before_recall", address, 'h1C);
    cyc(0, 1, 1, 4, 0, 0, 0, 1);
    chk("recall_addr", address, 'h14);
`endif

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
